// File: rtl/av2_recon_adder_if.sv
// Stream bundle for the reconstruction adder: block control, the residual and
// prediction input streams, the reconstructed output stream and status.
//
// Handshake semantics (all three streams): a beat transfers on a rising clk
// edge where valid && ready are both high. A source holds data stable while
// valid is high and ready is low; ready may depend combinationally on valid.
interface av2_recon_adder_if #(
  parameter int BIT_DEPTH = 10,
  parameter int RES_W     = 16
);
  logic                 start;
  logic [2:0]           blk_w_log2;
  logic [2:0]           blk_h_log2;
  logic [RES_W-1:0]     res_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [BIT_DEPTH-1:0] pred_data;
  logic                 pred_valid;
  logic                 pred_ready;
  logic [BIT_DEPTH-1:0] recon_data;
  logic [5:0]           recon_x;
  logic [5:0]           recon_y;
  logic                 recon_last;
  logic                 recon_valid;
  logic                 recon_ready;
  logic                 busy;
  logic                 done;

  // Adder side
  modport slave (
    input  start, blk_w_log2, blk_h_log2,
    input  res_data, res_valid, pred_data, pred_valid, recon_ready,
    output res_ready, pred_ready,
    output recon_data, recon_x, recon_y, recon_last, recon_valid,
    output busy, done
  );

  // Upstream/downstream side
  modport master (
    output start, blk_w_log2, blk_h_log2,
    output res_data, res_valid, pred_data, pred_valid, recon_ready,
    input  res_ready, pred_ready,
    input  recon_data, recon_x, recon_y, recon_last, recon_valid,
    input  busy, done
  );
endinterface

// File: rtl/av2_recon_adder.sv
// Reconstruction adder: joins the residual and prediction streams pixel by
// pixel, adds them, clips to the pixel range and emits raster-ordered pixels
// with coordinates through a single output register stage.
module av2_recon_adder #(
  parameter int BIT_DEPTH = 10,
  parameter int RES_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,        // asynchronous, active-high
  av2_recon_adder_if.slave     bus,
  output logic [1:0]           o_dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [RES_W+1:0] C_MAX_PIX =
    {{(RES_W+2-BIT_DEPTH){1'b0}}, {BIT_DEPTH{1'b1}}};

  logic [1:0]           r_state;
  logic [2:0]           r_w_log2;
  logic [2:0]           r_h_log2;
  logic [5:0]           r_x;
  logic [5:0]           r_y;
  logic                 r_valid;
  logic [BIT_DEPTH-1:0] r_data;
  logic [5:0]           r_out_x;
  logic [5:0]           r_out_y;
  logic                 r_last;

  logic                 w_accept;
  logic                 w_fire;
  logic [5:0]           w_x_max;
  logic [5:0]           w_y_max;
  logic                 w_x_end;
  logic                 w_y_end;
  logic signed [RES_W+1:0] w_sum;
  logic [BIT_DEPTH-1:0] w_clip;

  // Block dimensions outside 4..64 are pulled to the nearest legal size.
  function automatic logic [2:0] clamp_log2(input logic [2:0] v);
    if (v < 3'd2)      return 3'd2;
    else if (v > 3'd6) return 3'd6;
    else               return v;
  endfunction

  // A pair moves only when both streams are valid and the output slot is free
  // or being drained this cycle, so the two streams always transfer together.
  assign w_accept = (r_state == S_RUN) && (!r_valid || bus.recon_ready);
  assign w_fire   = w_accept && bus.res_valid && bus.pred_valid;

  assign w_x_max  = 6'((7'd1 << r_w_log2) - 7'd1);
  assign w_y_max  = 6'((7'd1 << r_h_log2) - 7'd1);
  assign w_x_end  = (r_x == w_x_max);
  assign w_y_end  = (r_y == w_y_max);

  assign w_sum = $signed({{2{bus.res_data[RES_W-1]}}, bus.res_data}) +
                 $signed({{(RES_W+2-BIT_DEPTH){1'b0}}, bus.pred_data});

  // Clip the widened sum into 0 .. 2^BIT_DEPTH-1.
  always_comb begin
    w_clip = '0;
    if (w_sum[RES_W+1])
      w_clip = '0;
    else if ($unsigned(w_sum) > C_MAX_PIX)
      w_clip = C_MAX_PIX[BIT_DEPTH-1:0];
    else
      w_clip = w_sum[BIT_DEPTH-1:0];
  end

  // Block FSM with raster counters and latched dimensions.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= S_IDLE;
      r_w_log2 <= '0;
      r_h_log2 <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_RUN;
            r_w_log2 <= clamp_log2(bus.blk_w_log2);
            r_h_log2 <= clamp_log2(bus.blk_h_log2);
            r_x      <= '0;
            r_y      <= '0;
          end
        end
        S_RUN: begin
          if (w_fire) begin
            if (w_x_end) begin
              r_x <= '0;
              r_y <= w_y_end ? 6'd0 : r_y + 6'd1;
              if (w_y_end) r_state <= S_DRAIN;
            end else begin
              r_x <= r_x + 6'd1;
            end
          end
        end
        S_DRAIN: begin
          if (r_valid && bus.recon_ready) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Single output stage: reload on every accepted pair, otherwise empty on accept.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_out_x <= '0;
      r_out_y <= '0;
      r_last  <= 1'b0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_data  <= w_clip;
      r_out_x <= r_x;
      r_out_y <= r_y;
      r_last  <= w_x_end && w_y_end;
    end else if (bus.recon_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.res_ready   = w_accept && bus.pred_valid;
  assign bus.pred_ready  = w_accept && bus.res_valid;
  assign bus.recon_valid = r_valid;
  assign bus.recon_data  = r_data;
  assign bus.recon_x     = r_out_x;
  assign bus.recon_y     = r_out_y;
  assign bus.recon_last  = r_last;
  assign bus.busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done        = (r_state == S_DONE);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_av2_recon_adder.sv
// Bench for av2_recon_adder: a pixel driver pushes the expected reconstructed
// beat for every accepted pair, a monitor pops and compares each output beat.
module tb_av2_recon_adder;
  localparam int BD = 10;
  localparam int RW = 16;
  localparam int EW = BD + 13;   // {data, x, y, last}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  av2_recon_adder_if #(.BIT_DEPTH(BD), .RES_W(RW)) bus();
  logic [1:0] dbg_state;

  av2_recon_adder #(.BIT_DEPTH(BD), .RES_W(RW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int beats = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp_dim(input logic [2:0] v);
    int c;
    c = int'(v);
    if (c < 2) c = 2;
    if (c > 6) c = 6;
    return 1 << c;
  endfunction

  function automatic int rand_res();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  // ---------------- downstream ready driver ----------------
  initial begin
    bus.recon_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.recon_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- output monitor ----------------
  logic          mon_stall = 1'b0;
  logic [EW-1:0] mon_held;
  logic [EW-1:0] mon_cur;
  logic [EW-1:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        mon_stall = 1'b0;
      end else begin
        mon_cur = {bus.recon_data, bus.recon_x, bus.recon_y, bus.recon_last};
        if (mon_stall) begin
          chk("stall_valid_held", 32'(bus.recon_valid), 1);
          chk("stall_beat_stable", 32'(mon_cur), 32'(mon_held));
        end
        if (bus.recon_valid && bus.recon_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got x=%0d y=%0d data=%0d expected none",
                     bus.recon_x, bus.recon_y, bus.recon_data);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("recon_data", 32'(bus.recon_data), 32'(mon_exp[EW-1 -: BD]));
            chk("recon_x",    32'(bus.recon_x),    32'(mon_exp[12:7]));
            chk("recon_y",    32'(bus.recon_y),    32'(mon_exp[6:1]));
            chk("recon_last", 32'(bus.recon_last), 32'(mon_exp[0]));
            beats++;
          end
        end
        mon_stall = bus.recon_valid && !bus.recon_ready;
        mon_held  = mon_cur;
      end
    end
  end

  // ---------------- done monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n && bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_with_done", 32'(bus.busy), 0);
      end
    end
  end

  // ---------------- pixel driver ----------------
  // mode 0: pred=512, res=k-8; mode 1: random; mode 2: clip corners then random
  task automatic run_block(input logic [2:0] w, input logic [2:0] h, input int mode,
                           input bit tog, input bit mid_start, input int limit,
                           input bit chk_time);
    int bw, bh, k, res, pred, sum, tries, start_cyc, d0, b0;
    bit got, fire;
    int clip_res[4];
    int clip_pred[4];
    clip_res  = '{100, -50, -32768, 32767};
    clip_pred = '{1000, 10, 0, 1023};
    bw = clamp_dim(w);
    bh = clamp_dim(h);
    @(negedge clk);
    bus.blk_w_log2 = w;
    bus.blk_h_log2 = h;
    bus.start = 1'b1;
    start_cyc = cyc;
    d0 = done_cnt;
    b0 = beats;
    k = 0;
    for (int y = 0; y < bh; y++) begin
      for (int x = 0; x < bw; x++) begin
        if (k == limit) return;
        if (mode == 0) begin
          pred = 512; res = k - 8;
        end else if (mode == 2 && k < 4) begin
          pred = clip_pred[k]; res = clip_res[k];
        end else begin
          pred = int'($urandom_range(0, 1023)); res = rand_res();
        end
        sum = res + pred;
        if (sum < 0) sum = 0;
        if (sum > 1023) sum = 1023;
        got = 1'b0;
        tries = 0;
        while (!got) begin
          @(negedge clk);
          bus.start = 1'b0;
          if (mid_start && k == 3 && tries == 0) begin
            bus.start = 1'b1;
            bus.blk_w_log2 = 3'd5;
          end
          bus.res_data   = 16'(res);
          bus.pred_data  = 10'(pred);
          bus.res_valid  = 1'b1;
          bus.pred_valid = tog ? (cyc % 2 == 0) : 1'b1;
          #1;
          chk("join_same_cycle", 32'(bus.res_valid && bus.res_ready),
              32'(bus.pred_valid && bus.pred_ready));
          fire = bus.res_valid && bus.res_ready && bus.pred_valid && bus.pred_ready;
          if (fire) begin
            exp_q.push_back({10'(sum), 6'(x), 6'(y), 1'(x == bw - 1 && y == bh - 1)});
            got = 1'b1;
          end
          tries++;
          if (!got && tries > 1000) begin
            total++;
            bad++;
            $display("FAIL input_timeout: pixel %0d not accepted after %0d cycles", k, tries);
            bus.res_valid = 1'b0;
            bus.pred_valid = 1'b0;
            return;
          end
        end
        k++;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.res_valid = 1'b0;
    bus.pred_valid = 1'b0;
    for (int i = 0; i < 20000 && done_cnt == d0; i++) begin
      @(negedge clk);
      #3;
    end
    chk("done_seen", 32'(done_cnt - d0), 1);
    chk("beat_count", 32'(beats - b0), 32'(bw * bh));
    chk("queue_empty", 32'(exp_q.size()), 0);
    if (chk_time) chk("done_timing", 32'(done_cyc - start_cyc), 32'(bw * bh + 2));
    repeat (3) @(negedge clk);
    #3;
    chk("done_single_pulse", 32'(done_cnt - d0), 1);
    chk("idle_after_block", 32'(dbg_state), 0);
  endtask

  // ---------------- main sequence ----------------
  int d_before;
  initial begin
    bus.start = 1'b0;
    bus.blk_w_log2 = 3'd0;
    bus.blk_h_log2 = 3'd0;
    bus.res_data = '0;
    bus.res_valid = 1'b0;
    bus.pred_data = '0;
    bus.pred_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_recon_valid", 32'(bus.recon_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b0;

    // Partial 4x4 block, then reset in the middle of RUN
    run_block(3'd2, 3'd2, 0, 1'b0, 1'b0, 5, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_recon_valid", 32'(bus.recon_valid), 0);
    chk("midrst_recon_data", 32'(bus.recon_data), 0);
    chk("midrst_recon_x", 32'(bus.recon_x), 0);
    chk("midrst_recon_y", 32'(bus.recon_y), 0);
    chk("midrst_recon_last", 32'(bus.recon_last), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_res_ready", 32'(bus.res_ready), 0);
    chk("midrst_pred_ready", 32'(bus.pred_ready), 0);
    exp_q.delete();
    d_before = done_cnt;
    bus.res_valid = 1'b0;
    bus.pred_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    chk("midrst_no_done", 32'(done_cnt - d_before), 0);
    chk("midrst_idle", 32'(dbg_state), 0);

    // Clean 4x4 ramp, full rate
    run_block(3'd2, 3'd2, 0, 1'b0, 1'b0, -1, 1'b1);
    // Clip corners
    run_block(3'd2, 3'd2, 2, 1'b0, 1'b0, -1, 1'b1);
    // 8x4 with toggling pred_valid and random backpressure
    rand_ready = 1'b1;
    run_block(3'd3, 3'd2, 1, 1'b1, 1'b0, -1, 1'b0);
    run_block(3'd4, 3'd3, 1, 1'b0, 1'b0, -1, 1'b0);
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);
    // 64x64 at full rate
    run_block(3'd6, 3'd6, 1, 1'b0, 1'b0, -1, 1'b1);
    // start during RUN is ignored
    run_block(3'd2, 3'd3, 1, 1'b0, 1'b1, -1, 1'b1);
    // clamped dimensions: 4x64
    run_block(3'd0, 3'd7, 1, 1'b0, 1'b0, -1, 1'b1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
